// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//
// Multi-cycle unsigned subtractor. Computes d = a - b over WIDTH bits,
// DIGIT bits per clock. The borrow is carried between digits in a
// flip-flop, so a wide subtract costs N = WIDTH/DIGIT cycles instead of a
// full-width carry chain.
//
// Parameters
//   WIDTH  operand/result width in bits (>= 2)
//   DIGIT  bits processed per RUN cycle (must divide WIDTH)
//
// Ports
//   clk    rising-edge clock
//   rst    asynchronous active-high reset
//   start  request, sampled only while idle; a and b are latched with it
//   a      minuend
//   b      subtrahend
//   busy   high while an operation is in progress
//   done   one-cycle pulse when d/bout hold a fresh result
//   d      difference a - b modulo 2^WIDTH
//   bout   final borrow, 1 iff a < b (unsigned)
//   ovf    (only with SUB_SIGNED_OVF_EN) two's-complement overflow flag
//
// Optional feature macro: SUB_SIGNED_OVF_EN adds the registered ovf output.
// All outputs are registered; none depends combinationally on an input.
// ---------------------------------------------------------------------------
module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout
`ifdef SUB_SIGNED_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] aSh_q, aSh_d;
    logic [WIDTH-1:0] bSh_q, bSh_d;
    logic [WIDTH-1:0] resSh_q, resSh_d;
    logic             borrow_q, borrow_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             bout_q, bout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef SUB_SIGNED_OVF_EN
    logic             aMsb_q, aMsb_d;
    logic             bMsb_q, bMsb_d;
    logic             ovf_q, ovf_d;
`endif

    // One digit of the subtraction, computed one bit wider than the digit so
    // the top bit is the borrow out. The new digit enters the result register
    // at the MSB end, so after N steps the first (least significant) digit has
    // been pushed down to bit 0.
    logic [DIGIT:0]   digitDiff;
    logic [WIDTH-1:0] resShifted;

    always_comb begin
        digitDiff  = {1'b0, aSh_q[DIGIT-1:0]}
                   - {1'b0, bSh_q[DIGIT-1:0]}
                   - {{DIGIT{1'b0}}, borrow_q};
        resShifted = (resSh_q >> DIGIT)
                   | (WIDTH'(digitDiff[DIGIT-1:0]) << (WIDTH - DIGIT));
    end

    // State register and all datapath registers. Reset clears everything,
    // including the visible result, and aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            aSh_q    <= '0;
            bSh_q    <= '0;
            resSh_q  <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            d_q      <= '0;
            bout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SUB_SIGNED_OVF_EN
            aMsb_q   <= 1'b0;
            bMsb_q   <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            aSh_q    <= aSh_d;
            bSh_q    <= bSh_d;
            resSh_q  <= resSh_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
            d_q      <= d_d;
            bout_q   <= bout_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef SUB_SIGNED_OVF_EN
            aMsb_q   <= aMsb_d;
            bMsb_q   <= bMsb_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    // Next-state and datapath control. Everything holds by default; done is
    // a pulse, so it falls back to 0 unless the last RUN edge raises it.
    // start is only looked at in IDLE, which gives the no-queueing behaviour.
    always_comb begin
        state_d  = state_q;
        aSh_d    = aSh_q;
        bSh_d    = bSh_q;
        resSh_d  = resSh_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        d_d      = d_q;
        bout_d   = bout_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
`ifdef SUB_SIGNED_OVF_EN
        aMsb_d   = aMsb_q;
        bMsb_d   = bMsb_q;
        ovf_d    = ovf_q;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    aSh_d    = a;
                    bSh_d    = b;
                    resSh_d  = '0;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = RUN;
`ifdef SUB_SIGNED_OVF_EN
                    aMsb_d   = a[WIDTH-1];
                    bMsb_d   = b[WIDTH-1];
`endif
                end
            end

            RUN: begin
                borrow_d = digitDiff[DIGIT];
                resSh_d  = resShifted;
                aSh_d    = aSh_q >> DIGIT;
                bSh_d    = bSh_q >> DIGIT;
                cnt_d    = cnt_q + CW'(1);
                // Publish the result only on the final digit so partial
                // differences never appear on d.
                if (cnt_q == LAST) begin
                    d_d     = resShifted;
                    bout_d  = digitDiff[DIGIT];
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
`ifdef SUB_SIGNED_OVF_EN
                    // Signed overflow: operands of opposite sign and a
                    // result whose sign differs from the minuend.
                    ovf_d   = (aMsb_q != bMsb_q) &&
                              (resShifted[WIDTH-1] != aMsb_q);
`endif
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign busy = busy_q;
    assign done = done_q;
    assign d    = d_q;
    assign bout = bout_q;
`ifdef SUB_SIGNED_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor
//
// Three instances share clock, reset and operand inputs: DIGIT = 1, 4 and 8
// at WIDTH = 8, so N = 8, 2 and 1. Expected results come from plain integer
// arithmetic on the operands; expected latency is WIDTH/DIGIT.
// ---------------------------------------------------------------------------
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;

    logic [2:0]      busyV;
    logic [2:0]      doneV;
    logic [2:0]      boutV;
    logic [2:0][7:0] dV;
`ifdef SUB_SIGNED_OVF_EN
    logic [2:0]      ovfV;
`endif

    int compared   = 0;
    int mismatched = 0;

    // Last published result per instance; d must hold it until completion.
    logic [7:0] lastD [3];
    logic       lastB [3];

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] d;
        logic       bout;
        logic       ovf;
    } vec_t;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8), .DIGIT(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busyV[0]), .done(doneV[0]), .d(dV[0]), .bout(boutV[0])
`ifdef SUB_SIGNED_OVF_EN
        , .ovf(ovfV[0])
`endif
    );

    serial_subtractor #(.WIDTH(8), .DIGIT(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busyV[1]), .done(doneV[1]), .d(dV[1]), .bout(boutV[1])
`ifdef SUB_SIGNED_OVF_EN
        , .ovf(ovfV[1])
`endif
    );

    serial_subtractor #(.WIDTH(8), .DIGIT(8)) dut8 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busyV[2]), .done(doneV[2]), .d(dV[2]), .bout(boutV[2])
`ifdef SUB_SIGNED_OVF_EN
        , .ovf(ovfV[2])
`endif
    );

    function automatic int latOf(input int i);
        return (i == 0) ? 8 : ((i == 1) ? 2 : 1);
    endfunction

    // Reference model: modular difference, unsigned borrow, signed overflow.
    function automatic logic [7:0] refD(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] r;
        r = x - y;
        return r;
    endfunction

    function automatic logic refB(input logic [7:0] x, input logic [7:0] y);
        return (x < y);
    endfunction

    function automatic logic refOvf(input logic [7:0] x, input logic [7:0] y);
        int sx;
        int sy;
        sx = $signed(x);
        sy = $signed(y);
        return ((sx - sy) > 127) || ((sx - sy) < -128);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One start on all three instances, then 12 edges of observation.
    task automatic applyStimulus(input logic [7:0] va, input logic [7:0] vb,
                                 input logic [7:0] ed, input logic eb,
                                 input logic eo, input string tag);
        int         doneAt  [3];
        int         doneCnt [3];
        logic [7:0] capD    [3];
        logic       capB    [3];
        logic       capO    [3];
        for (int i = 0; i < 3; i++) begin
            doneAt[i]  = -1;
            doneCnt[i] = 0;
            capD[i]    = '0;
            capB[i]    = 1'b0;
            capO[i]    = 1'b0;
        end
        @(negedge clk);
        a = va;
        b = vb;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        checkOutput({tag, " busy after start"}, {29'd0, busyV}, 32'd7);
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                checkOutput($sformatf("%s dut%0d busy c%0d", tag, i, c),
                            {31'd0, busyV[i]}, {31'd0, (c < latOf(i))});
                if (c < latOf(i))
                    checkOutput($sformatf("%s dut%0d d held c%0d", tag, i, c),
                                {24'd0, dV[i]}, {24'd0, lastD[i]});
                if (doneV[i]) begin
                    doneCnt[i]++;
                    if (doneAt[i] < 0) begin
                        doneAt[i] = c;
                        capD[i]   = dV[i];
                        capB[i]   = boutV[i];
`ifdef SUB_SIGNED_OVF_EN
                        capO[i]   = ovfV[i];
`endif
                    end
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("%s dut%0d latency", tag, i), doneAt[i], latOf(i));
            checkOutput($sformatf("%s dut%0d done pulses", tag, i), doneCnt[i], 1);
            checkOutput($sformatf("%s dut%0d d", tag, i), {24'd0, capD[i]}, {24'd0, ed});
            checkOutput($sformatf("%s dut%0d bout", tag, i), {31'd0, capB[i]}, {31'd0, eb});
`ifdef SUB_SIGNED_OVF_EN
            checkOutput($sformatf("%s dut%0d ovf", tag, i), {31'd0, capO[i]}, {31'd0, eo});
`else
            if (eo !== capO[i] && eo === 1'bz) $display("[TB] unreachable");
`endif
            lastD[i] = ed;
            lastB[i] = eb;
        end
    endtask

    vec_t vecs [8];

    initial begin
        int         doneAt0 [2];
        int         nDone;
        logic [7:0] ra;
        logic [7:0] rb;

        vecs[0] = '{a: 8'h35, b: 8'h12, d: 8'h23, bout: 1'b0, ovf: 1'b0};
        vecs[1] = '{a: 8'h12, b: 8'h35, d: 8'hDD, bout: 1'b1, ovf: 1'b0};
        vecs[2] = '{a: 8'h00, b: 8'h01, d: 8'hFF, bout: 1'b1, ovf: 1'b0};
        vecs[3] = '{a: 8'h5A, b: 8'h5A, d: 8'h00, bout: 1'b0, ovf: 1'b0};
        vecs[4] = '{a: 8'hA5, b: 8'h5A, d: 8'h4B, bout: 1'b0, ovf: 1'b1};
        vecs[5] = '{a: 8'h80, b: 8'h01, d: 8'h7F, bout: 1'b0, ovf: 1'b1};
        vecs[6] = '{a: 8'h7F, b: 8'hFF, d: 8'h80, bout: 1'b1, ovf: 1'b1};
        vecs[7] = '{a: 8'h05, b: 8'h03, d: 8'h02, bout: 1'b0, ovf: 1'b0};

        for (int i = 0; i < 3; i++) begin
            lastD[i] = '0;
            lastB[i] = 1'b0;
        end

        // Reset state
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        #12;
        checkOutput("reset busy", {29'd0, busyV}, 32'd0);
        checkOutput("reset done", {29'd0, doneV}, 32'd0);
        checkOutput("reset bout", {29'd0, boutV}, 32'd0);
        checkOutput("reset d", {8'd0, dV}, 32'd0);
`ifdef SUB_SIGNED_OVF_EN
        checkOutput("reset ovf", {29'd0, ovfV}, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // Directed table
        for (int v = 0; v < 8; v++)
            applyStimulus(vecs[v].a, vecs[v].b, vecs[v].d, vecs[v].bout,
                          vecs[v].ovf, $sformatf("vec%0d", v));

        // Randomized against the arithmetic model
        for (int r = 0; r < 30; r++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            if (r == 0) rb = ra;
            applyStimulus(ra, rb, refD(ra, rb), refB(ra, rb), refOvf(ra, rb),
                          $sformatf("rnd%0d", r));
        end

        // start pulsed at edge k+3 of a running operation
        begin
            int         cnt  [3];
            int         at0;
            logic [7:0] dFirst [3];
            logic [7:0] dLast  [3];
            for (int i = 0; i < 3; i++) begin
                cnt[i]    = 0;
                dFirst[i] = '0;
                dLast[i]  = '0;
            end
            at0 = -1;
            @(negedge clk);
            a = 8'h35;
            b = 8'h12;
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            for (int c = 1; c <= 12; c++) begin
                @(posedge clk);
                #1;
                if (c == 2) begin
                    a = 8'hFF;
                    b = 8'h01;
                    start = 1'b1;
                end
                if (c == 3) start = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    if (doneV[i]) begin
                        if (cnt[i] == 0) dFirst[i] = dV[i];
                        dLast[i] = dV[i];
                        cnt[i]++;
                        if (i == 0 && at0 < 0) at0 = c;
                    end
                end
            end
            checkOutput("ignore dut1 latency", at0, 8);
            checkOutput("ignore dut1 pulses", cnt[0], 1);
            checkOutput("ignore dut1 d", {24'd0, dFirst[0]}, 32'h23);
            checkOutput("ignore dut4 pulses", cnt[1], 1);
            checkOutput("ignore dut4 d", {24'd0, dFirst[1]}, 32'h23);
            checkOutput("ignore dut8 pulses", cnt[2], 2);
            checkOutput("ignore dut8 second d", {24'd0, dLast[2]}, 32'hFE);
            lastD[0] = 8'h23;
            lastD[1] = 8'h23;
            lastD[2] = 8'hFE;
        end

        // start held high: next operation begins on the first IDLE cycle
        nDone = 0;
        doneAt0[0] = -1;
        doneAt0[1] = -1;
        @(negedge clk);
        a = 8'h12;
        b = 8'h35;
        start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (c == 19) start = 1'b0;
            if (doneV[0]) begin
                if (nDone < 2) doneAt0[nDone] = c;
                nDone++;
                checkOutput($sformatf("held d c%0d", c), {24'd0, dV[0]}, 32'hDD);
                checkOutput($sformatf("held bout c%0d", c), {31'd0, boutV[0]}, 32'd1);
            end
        end
        checkOutput("held pulses", nDone, 2);
        checkOutput("held first done", doneAt0[0], 8);
        checkOutput("held second done", doneAt0[1], 18);
        repeat (12) @(posedge clk);
        #1;
        checkOutput("held drained busy", {29'd0, busyV}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("held dut%0d final d", i), {24'd0, dV[i]}, 32'hDD);
            lastD[i] = 8'hDD;
            lastB[i] = 1'b1;
        end

        // Asynchronous reset in RUN cycle 4
        @(negedge clk);
        a = 8'h35;
        b = 8'h12;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        checkOutput("pre-reset busy dut1", {31'd0, busyV[0]}, 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("async rst busy", {29'd0, busyV}, 32'd0);
        checkOutput("async rst done", {29'd0, doneV}, 32'd0);
        checkOutput("async rst bout", {29'd0, boutV}, 32'd0);
        checkOutput("async rst d", {8'd0, dV}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        nDone = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            if (doneV != 3'b000) nDone++;
        end
        checkOutput("no done after reset", nDone, 0);
        for (int i = 0; i < 3; i++) begin
            lastD[i] = '0;
            lastB[i] = 1'b0;
        end
        applyStimulus(8'hC3, 8'h3C, refD(8'hC3, 8'h3C), refB(8'hC3, 8'h3C),
                      refOvf(8'hC3, 8'h3C), "post-reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Hard time limit so a stuck design still ends the run.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation exceeded time limit");
        $fatal(1, "[TB] timeout");
    end

endmodule
